// File: rtl/digit_serial_mult.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier. It feeds one 2-bit digit pair per cycle
// to an external combinational 2x2 stage and shift-accumulates the 4-bit results.
module digit_serial_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         mult_a,
  output logic [1:0]         mult_b,
  input  logic [3:0]         mult_result
);

  localparam int N  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, next_state;

  logic [N-1:0][1:0] ra, rb;
  logic [PW-1:0]     acc, term, sum;
  logic [IW-1:0]     i, j;
  logic [IW:0]       idx_sum;
  logic [IW+1:0]     shamt;
  logic              last;

  // Weight of the current partial product is 4^(i+j).
  assign idx_sum = {1'b0, i} + {1'b0, j};
  assign shamt   = {idx_sum, 1'b0};
  assign term    = PW'(mult_result) << shamt;
  assign sum     = acc + term;
  assign last    = (i == LAST_IDX) && (j == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    mult_a     = 2'b00;
    mult_b     = 2'b00;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        mult_a = ra[i];
        mult_b = rb[j];
        if (last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: j is the inner index, i the outer; product only moves on the final term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra      <= '0;
      rb      <= '0;
      acc     <= '0;
      i       <= '0;
      j       <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= op_a;
            rb  <= op_b;
            acc <= '0;
            i   <= '0;
            j   <= '0;
          end
        end
        RUN: begin
          acc <= sum;
          if (last) begin
            product <= sum;
            i       <= '0;
            j       <= '0;
          end else if (j == LAST_IDX) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_mult.sv
// Self-checking bench for digit_serial_mult: an 8-bit and a 2-bit instance, each wired to
// a behavioural 2x2 stage, with expected products queued at start and popped on done.
module tb_digit_serial_mult;

  logic        clk;
  logic        rst;

  logic        start8;
  logic [7:0]  op_a8, op_b8;
  logic        busy8, done8;
  logic [15:0] product8;
  logic [1:0]  mult_a8, mult_b8;
  logic [3:0]  mult_result8;

  logic        start2;
  logic [1:0]  op_a2, op_b2;
  logic        busy2, done2;
  logic [3:0]  product2;
  logic [1:0]  mult_a2, mult_b2;
  logic [3:0]  mult_result2;

  int checks = 0;
  int errors = 0;

  logic [15:0] q8[$];
  logic [3:0]  q2[$];
  logic [15:0] last_prod8;

  digit_serial_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op_a(op_a8), .op_b(op_b8),
    .busy(busy8), .done(done8), .product(product8),
    .mult_a(mult_a8), .mult_b(mult_b8), .mult_result(mult_result8)
  );

  digit_serial_mult #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_a(op_a2), .op_b(op_b2),
    .busy(busy2), .done(done2), .product(product2),
    .mult_a(mult_a2), .mult_b(mult_b2), .mult_result(mult_result2)
  );

  // Behavioural 2x2 combinational stage
  assign mult_result8 = {2'b00, mult_a8} * {2'b00, mult_b8};
  assign mult_result2 = {2'b00, mult_a2} * {2'b00, mult_b2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at the negedge of the first RUN cycle (c=0).
  task automatic pulse_start8(input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1;
    op_a8  = a;
    op_b8  = b;
    q8.push_back(16'(a) * 16'(b));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start8 = 1'b0; op_a8 = '0; op_b8 = '0;
    start2 = 1'b0; op_a2 = '0; op_b2 = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy8, done8, product8, mult_a8, mult_b8} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL reset8 got busy=%0b done=%0b product=%h ma=%0d mb=%0d exp all 0",
               busy8, done8, product8, mult_a8, mult_b8);
    end
    checks++;
    if ({busy2, done2, product2, mult_a2, mult_b2} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset2 got busy=%0b done=%0b product=%h exp all 0", busy2, done2, product2);
    end
    rst = 1'b0;
    @(negedge clk);
    last_prod8 = 16'h0000;
  endtask

  task automatic test_latency;
    int busy_cnt = 0;
    int done_cnt = 0;
    pulse_start8(8'd3, 8'd3);
    for (int c = 0; c < 20; c++) begin
      if (busy8) busy_cnt++;
      checks++;
      if (done8 !== (c == 16)) begin
        errors++;
        $display("[TB] FAIL latency_done c=%0d got %0b exp %0b", c, done8, (c == 16));
      end
      if (done8) begin
        done_cnt++;
        checks++;
        if (q8.size() == 0 || product8 !== q8[0]) begin
          errors++;
          $display("[TB] FAIL latency_product got %h exp %h", product8, 16'h0009);
        end
        if (q8.size() != 0) last_prod8 = q8.pop_front();
      end
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != 17) begin
      errors++;
      $display("[TB] FAIL latency_busy_cycles got %0d exp 17", busy_cnt);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL latency_done_count got %0d exp 1", done_cnt);
    end
  endtask

  task automatic test_digits;
    logic [1:0] ea, eb;
    int done_cnt;
    // All-ones operands: every digit pair is (3,3)
    done_cnt = 0;
    pulse_start8(8'hFF, 8'hFF);
    for (int c = 0; c < 18; c++) begin
      ea = (c < 16) ? 2'd3 : 2'd0;
      checks++;
      if (mult_a8 !== ea || mult_b8 !== ea) begin
        errors++;
        $display("[TB] FAIL ff_digits c=%0d got (%0d,%0d) exp (%0d,%0d)", c, mult_a8, mult_b8, ea, ea);
      end
      if (done8) begin
        done_cnt++;
        checks++;
        if (q8.size() == 0 || product8 !== q8[0]) begin
          errors++;
          $display("[TB] FAIL ff_product got %h exp %h", product8, 16'hFE01);
        end
        if (q8.size() != 0) last_prod8 = q8.pop_front();
      end
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL ff_done_count got %0d exp 1", done_cnt);
    end
    // 8'hE4 has digit k equal to k, so the driven digits expose the (i,j) order
    done_cnt = 0;
    pulse_start8(8'hE4, 8'hE4);
    for (int c = 0; c < 18; c++) begin
      ea = (c < 16) ? 2'(c / 4) : 2'd0;
      eb = (c < 16) ? 2'(c % 4) : 2'd0;
      checks++;
      if (mult_a8 !== ea || mult_b8 !== eb) begin
        errors++;
        $display("[TB] FAIL order_digits c=%0d got (%0d,%0d) exp (%0d,%0d)", c, mult_a8, mult_b8, ea, eb);
      end
      if (done8) begin
        done_cnt++;
        checks++;
        if (q8.size() == 0 || product8 !== q8[0]) begin
          errors++;
          $display("[TB] FAIL order_product got %h exp %h", product8, 16'hCB10);
        end
        if (q8.size() != 0) last_prod8 = q8.pop_front();
      end
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL order_done_count got %0d exp 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int done_cnt = 0;
    pulse_start8(8'h00, 8'hAB);
    for (int c = 0; c < 17; c++) begin
      if (done8) begin
        done_cnt++;
        checks++;
        if (q8.size() == 0 || product8 !== q8[0]) begin
          errors++;
          $display("[TB] FAIL b2b_first_product got %h exp %h", product8, 16'h0000);
        end
        if (q8.size() != 0) last_prod8 = q8.pop_front();
      end
      // Raised during DONE (ignored) and held into the first IDLE cycle (accepted)
      if (c == 16) begin
        start8 = 1'b1;
        op_a8  = 8'hAB;
        op_b8  = 8'h01;
      end
      @(negedge clk);
    end
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle_gap got busy=%0b done=%0b exp 0 0", busy8, done8);
    end
    q8.push_back(16'h00AB);
    @(negedge clk);
    start8 = 1'b0;
    op_a8  = 8'h55;
    op_b8  = 8'h55;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        checks++;
        if (product8 !== last_prod8 || busy8 !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_hold c=%0d got product=%h busy=%0b exp %h 1", c, product8, busy8, last_prod8);
        end
      end
      if (done8) begin
        done_cnt++;
        checks++;
        if (c != 16 || q8.size() == 0 || product8 !== q8[0]) begin
          errors++;
          $display("[TB] FAIL b2b_second_product c=%0d got %h exp %h at c=16", c, product8, 16'h00AB);
        end
        if (q8.size() != 0) last_prod8 = q8.pop_front();
      end
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 2) begin
      errors++;
      $display("[TB] FAIL b2b_done_count got %0d exp 2", done_cnt);
    end
  endtask

  task automatic test_ignore_start;
    int done_cnt = 0;
    pulse_start8(8'h12, 8'h34);
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin
        checks++;
        if (product8 !== last_prod8) begin
          errors++;
          $display("[TB] FAIL ignore_hold c=%0d got %h exp %h", c, product8, last_prod8);
        end
      end
      if (c >= 17) begin
        checks++;
        if (busy8 !== 1'b0) begin
          errors++;
          $display("[TB] FAIL ignore_restart c=%0d busy got %0b exp 0", c, busy8);
        end
      end
      if (done8) begin
        done_cnt++;
        checks++;
        if (q8.size() == 0 || product8 !== q8[0]) begin
          errors++;
          $display("[TB] FAIL ignore_product got %h exp %h", product8, 16'h03A8);
        end
        if (q8.size() != 0) last_prod8 = q8.pop_front();
      end
      if (c == 5) begin
        start8 = 1'b1;
        op_a8  = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL ignore_done_count got %0d exp 1", done_cnt);
    end
  endtask

  task automatic test_mid_reset;
    int done_cnt = 0;
    pulse_start8(8'hC8, 8'h64);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    q8.delete();
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL midreset got busy=%0b done=%0b product=%h exp 0 0 0000", busy8, done8, product8);
    end
    @(negedge clk);
    rst = 1'b0;
    last_prod8 = 16'h0000;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_quiet c=%0d got busy=%0b done=%0b exp 0 0", c, busy8, done8);
      end
      @(negedge clk);
    end
    pulse_start8(8'hC8, 8'h64);
    for (int c = 0; c < 18; c++) begin
      if (done8) begin
        done_cnt++;
        checks++;
        if (c != 16 || q8.size() == 0 || product8 !== q8[0]) begin
          errors++;
          $display("[TB] FAIL midreset_product c=%0d got %h exp %h at c=16", c, product8, 16'h4E20);
        end
        if (q8.size() != 0) last_prod8 = q8.pop_front();
      end
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL midreset_done_count got %0d exp 1", done_cnt);
    end
  endtask

  task automatic test_width2;
    int done_cnt = 0;
    start2 = 1'b1;
    op_a2  = 2'b11;
    op_b2  = 2'b10;
    q2.push_back(4'b0110);
    @(negedge clk);
    start2 = 1'b0;
    op_a2  = 2'b00;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (busy2 !== (c <= 1) || done2 !== (c == 1)) begin
        errors++;
        $display("[TB] FAIL w2_timing c=%0d got busy=%0b done=%0b exp %0b %0b", c, busy2, done2, (c <= 1), (c == 1));
      end
      if (done2) begin
        done_cnt++;
        checks++;
        if (q2.size() == 0 || product2 !== q2[0]) begin
          errors++;
          $display("[TB] FAIL w2_product got %b exp %b", product2, 4'b0110);
        end
        if (q2.size() != 0) void'(q2.pop_front());
      end
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL w2_done_count got %0d exp 1", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_digits();
    test_back_to_back();
    test_ignore_start();
    test_mid_reset();
    test_width2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_mult.md
Name: digit_serial_mult

Overview:
- Sequential WIDTH x WIDTH unsigned multiplier built around the existing 2-bit x 2-bit combinational multiplier stage.
- Splits both operands into 2-bit digits and feeds one digit pair per cycle to the 2x2 stage through its a/b inputs.
- Consumes the stage's 4-bit result on the same cycle and shift-accumulates it into a 2*WIDTH-bit product.
- Sits directly upstream (driver) and downstream (consumer) of the 2x2 multiplier instance.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2; N = WIDTH/2 digits per operand.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request pulse; accepted only in IDLE.
- op_a  input  WIDTH  multiplicand; sampled on the accepting edge.
- op_b  input  WIDTH  multiplier; sampled on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  registered result; held until the next completion.
- mult_a  output  2  digit of op_a driven to the 2x2 stage's a input.
- mult_b  output  2  digit of op_b driven to the 2x2 stage's b input.
- mult_result  input  4  combinational product returned from the 2x2 stage (same cycle).

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, product=0, internal acc=0, indices i=j=0, mult_a=mult_b=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - mult_a=mult_b=0.
  - On an edge with start=1: latch op_a/op_b into ra/rb, clear acc to 0, set i=0 and j=0, go to RUN.
- RUN (exactly N*N cycles):
  - Drive mult_a=ra[2i+1:2i] and mult_b=rb[2j+1:2j].
  - On each edge: acc <= acc + (zero-extend(mult_result) << 2*(i+j)), computed at 2*WIDTH bits. No overflow is possible.
  - Index order: j increments first. When j=N-1, j wraps to 0 and i increments.
  - On the edge where i=N-1 and j=N-1: product <= final sum (acc plus this last term), go to DONE.
- DONE:
  - done=1 for exactly one cycle, mult_a=mult_b=0, then go to IDLE.
- Latency: start accepted at edge k; product and done become visible after edge k+N*N; done is high for the cycle between edges k+N*N and k+N*N+1. For WIDTH=8 this is 16 RUN cycles.
- busy is high from the cycle after the accepting edge through the DONE cycle inclusive; it is 0 again in the first IDLE cycle.
- start while busy (RUN or DONE) is ignored: no restart, no latch. The earliest accepted back-to-back start is the edge ending the first IDLE cycle after DONE.
- op_a/op_b changes after acceptance have no effect on the operation in progress.
- product changes only on the RUN->DONE transition or on reset. It is stable at all other times, including during a new RUN.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE.
  - product is cleared to 0.
  - No done pulse.
  - A start is accepted normally after rst deasserts.
- mult_result is trusted as correct for the driven digits. No registering is inserted between mult_a/mult_b and mult_result.
- WIDTH=2 (N=1): RUN lasts 1 cycle. The single term is unshifted.

Test Plan:
- WIDTH=8, op_a=3, op_b=3, start pulse at edge k -> busy=1 for 17 cycles; done=1 exactly in the cycle after edge k+16; product=16'h0009.
- op_a=8'hFF, op_b=8'hFF -> product=16'hFE01. mult_a/mult_b step through (0,0),(0,1),(0,2),(0,3),(1,0),…,(3,3), each digit equal to 2'b11.
- op_a=8'h00, op_b=8'hAB, then op_a=8'hAB, op_b=8'h01 back-to-back (second start in the first IDLE cycle after DONE) -> product=0, then product=16'h00AB; the 0 stays held through the second RUN.
- Start a 8'h12 x 8'h34 operation; pulse start with op_a=8'hFF at RUN cycle 5 -> ignored; product=16'h03A8, done pulses once.
- Start 8'hC8 x 8'h64; assert rst at RUN cycle 7 -> busy=0, done=0, product=0 immediately. After release, 8'hC8 x 8'h64 -> product=16'h4E20.
- WIDTH=2 instance, op_a=2'b11, op_b=2'b10 -> product=4'b0110, with done in the cycle after edge k+1.
